// File: rtl/int_div_sched.sv
// int_div_sched: tagged request FIFO plus single-job scheduler wrapped around an iterative divider.
// Optional macro DIV_SCHED_DBZ_BYPASS_EN: zero-divisor requests skip the divider and return all ones.
module int_div_sched #(
  parameter int WIDTH = 12,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_dvd,
  input  logic [WIDTH-1:0]             in_dvs,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_quo,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         out_dbz,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         div_cal,
  output logic [WIDTH-1:0]             div_dvd,
  output logic [WIDTH-1:0]             div_dvs,
  input  logic [WIDTH-1:0]             div_quo,
  input  logic                         div_rdy
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, HOLD} state_e;

  logic [WIDTH-1:0] fifo_dvd_q [DEPTH];
  logic [WIDTH-1:0] fifo_dvs_q [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             push, pop;
  logic [WIDTH-1:0] head_dvd, head_dvs;
  logic [TAG_W-1:0] head_tag;

  state_e           state_q, state_d;
  logic             guard_q, guard_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_quo_q, out_quo_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [WIDTH-1:0] job_dvd_q, job_dvd_d;
  logic [WIDTH-1:0] job_dvs_q, job_dvs_d;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
  logic             out_dbz_q, out_dbz_d;
`endif

  // Space is judged from the registered count only, so a same-cycle pop never frees a slot.
  assign in_ready = (count_q != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign level    = count_q;
  assign head_dvd = fifo_dvd_q[rd_ptr_q];
  assign head_dvs = fifo_dvs_q[rd_ptr_q];
  assign head_tag = fifo_tag_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dvd_q[wr_ptr_q] <= in_dvd;
      fifo_dvs_q[wr_ptr_q] <= in_dvs;
      fifo_tag_q[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      guard_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_quo_q   <= '0;
      out_tag_q   <= '0;
      job_dvd_q   <= '0;
      job_dvs_q   <= '0;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
      out_dbz_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      guard_q     <= guard_d;
      out_valid_q <= out_valid_d;
      out_quo_q   <= out_quo_d;
      out_tag_q   <= out_tag_d;
      job_dvd_q   <= job_dvd_d;
      job_dvs_q   <= job_dvs_d;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
      out_dbz_q   <= out_dbz_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    guard_d     = guard_q;
    out_valid_d = out_valid_q;
    out_quo_d   = out_quo_q;
    out_tag_d   = out_tag_q;
    job_dvd_d   = job_dvd_q;
    job_dvs_d   = job_dvs_q;
    pop         = 1'b0;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
    out_dbz_d   = out_dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if ((count_q != '0) && div_rdy) begin
          pop       = 1'b1;
          job_dvd_d = head_dvd;
          job_dvs_d = head_dvs;
          out_tag_d = head_tag;
          state_d   = ISSUE;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
          if (head_dvs == '0) begin
            out_quo_d = '1;
            out_dbz_d = 1'b1;
            state_d   = HOLD;
          end
`endif
        end
      end
      ISSUE: begin
        guard_d = 1'b1;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // The divider may still show the previous ready in the first cycle after the pulse.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (div_rdy) begin
          out_quo_d   = div_quo;
          out_valid_d = 1'b1;
          state_d     = HOLD;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
          out_dbz_d   = 1'b0;
`endif
        end
      end
      HOLD: begin
        // A bypassed job enters HOLD with valid still low; raise it one cycle later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_quo   = out_quo_q;
  assign out_tag   = out_tag_q;
  assign div_cal   = (state_q == ISSUE);
  assign div_dvd   = job_dvd_q;
  assign div_dvs   = job_dvs_q;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
  assign out_dbz   = out_dbz_q;
`else
  assign out_dbz   = 1'b0;
`endif

endmodule

// File: tb/tb_int_div_sched.sv
// Scoreboard bench for int_div_sched with a behavioural iterative-divider model attached.
module tb_int_div_sched;
  localparam int WIDTH = 12;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
`ifdef DIV_SCHED_DBZ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst;
  logic in_valid, in_ready;
  logic [WIDTH-1:0] in_dvd, in_dvs;
  logic [TAG_W-1:0] in_tag;
  logic out_valid, out_ready;
  logic [WIDTH-1:0] out_quo;
  logic [TAG_W-1:0] out_tag;
  logic out_dbz;
  logic [2:0] level;
  logic div_cal;
  logic [WIDTH-1:0] div_dvd, div_dvs, div_quo;
  logic div_rdy;

  int_div_sched #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dvd(in_dvd), .in_dvs(in_dvs), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_quo(out_quo), .out_tag(out_tag),
    .out_dbz(out_dbz), .level(level),
    .div_cal(div_cal), .div_dvd(div_dvd), .div_dvs(div_dvs), .div_quo(div_quo), .div_rdy(div_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] quo;
    logic [TAG_W-1:0] tag;
    logic             dbz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cal_cnt = 0;
  int last_acc = 0;

  // Divider model: ready returns WIDTH+2 cycles after the cycle holding the start pulse.
  logic             dm_busy;
  int               dm_cnt;
  logic [WIDTH-1:0] dm_res;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_cal) cal_cnt <= cal_cnt + 1;
    if (rst) begin
      div_rdy <= 1'b1;
      dm_busy <= 1'b0;
      dm_cnt  <= 0;
      div_quo <= '0;
    end else if (div_cal) begin
      div_rdy <= 1'b0;
      dm_busy <= 1'b1;
      dm_cnt  <= WIDTH + 1;
      dm_res  <= (div_dvs == '0) ? '1 : div_dvd / div_dvs;
    end else if (dm_busy) begin
      if (dm_cnt == 1) begin
        div_rdy <= 1'b1;
        dm_busy <= 1'b0;
        div_quo <= dm_res;
      end else begin
        dm_cnt <= dm_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: tag %0d quo 0x%0h with nothing pending", out_tag, out_quo);
      end else begin
        mon_e = sb.pop_front();
        chk("out_quo", int'(out_quo), int'(mon_e.quo));
        chk("out_tag", int'(out_tag), int'(mon_e.tag));
        chk("out_dbz", int'(out_dbz), int'(mon_e.dbz));
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] q, input logic z);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1'b1; in_dvd = a; in_dvs = b; in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: tag %0d never accepted, in_ready %0d required 1", t, in_ready);
    end
    @(posedge clk);
    e.quo = q; e.tag = t; e.dbz = z;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk(name, cyc - last_acc, exp_lat);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    #1;
    chk("sb_drained", sb.size(), 0);
  endtask

  int c0, rises, prev_v, nvalid;
  int rise_at[8];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_dvd = '0; in_dvs = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_level", int'(level), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_quo", int'(out_quo), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    chk("rst_out_dbz", int'(out_dbz), 0);
    chk("rst_div_cal", int'(div_cal), 0);
    chk("rst_div_dvd", int'(div_dvd), 0);
    chk("rst_div_dvs", int'(div_dvs), 0);

    // Single request latency and pulse count.
    @(posedge clk); #1;
    c0 = cal_cnt;
    push(12'd100, 12'd7, 4'd3, 12'd14, 1'b0);
    wait_valid("latency_normal", WIDTH + 4);
    chk("cal_pulses_single", cal_cnt - c0, 1);
    drain(50);

    // Backpressure: six requests with out_ready low.
    out_ready = 1'b0;
    @(posedge clk); #1;
    push(12'd4095, 12'd1,    4'd1,  12'd4095, 1'b0);
    push(12'd0,    12'd5,    4'd2,  12'd0,    1'b0);
    push(12'd7,    12'd100,  4'd5,  12'd0,    1'b0);
    push(12'd4095, 12'd4095, 4'd8,  12'd1,    1'b0);
    push(12'd2048, 12'd3,    4'd10, 12'd682,  1'b0);
    @(negedge clk);
    chk("full_level", int'(level), DEPTH);
    chk("full_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_dvd = 12'd1000; in_dvs = 12'd10; in_tag = 4'd15;
    repeat (20) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_level", int'(level), DEPTH);
    chk("stall_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pop_cycle_in_ready", int'(in_ready), 0);
    chk("pop_cycle_level", int'(level), DEPTH);
    @(negedge clk);
    chk("after_pop_in_ready", int'(in_ready), 1);
    chk("after_pop_level", int'(level), DEPTH - 1);
    @(posedge clk);
    mon_e.quo = 12'd100; mon_e.tag = 4'd15; mon_e.dbz = 1'b0;
    sb.push_back(mon_e);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("refill_level", int'(level), DEPTH);
    rises = 0; prev_v = 0;
    for (int i = 0; i < 5 * (WIDTH + 5) + 30; i++) begin
      @(negedge clk);
      if (out_valid && prev_v == 0 && rises < 8) begin
        rise_at[rises] = cyc;
        rises++;
      end
      prev_v = int'(out_valid);
    end
    chk("drain_results", rises, 5);
    for (int k = 1; k < 5; k++) chk("throughput_gap", rise_at[k] - rise_at[k-1], WIDTH + 5);
    drain(50);

    // Zero divisor.
    @(posedge clk); #1;
    c0 = cal_cnt;
    push(12'd50, 12'd0, 4'd9, 12'hFFF, BYP);
    wait_valid("latency_dbz", BYP ? 2 : WIDTH + 4);
    chk("cal_pulses_dbz", cal_cnt - c0, BYP ? 0 : 1);
    drain(50);

    // Reset while a job waits on the divider with two more queued.
    @(posedge clk); #1;
    push(12'd300, 12'd20, 4'd4, 12'd15, 1'b0);
    push(12'd9,   12'd3,  4'd6, 12'd3,  1'b0);
    push(12'd77,  12'd7,  4'd7, 12'd11, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_level", int'(level), 2);
    chk("pre_reset_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_level", int'(level), 0);
    chk("post_reset_out_valid", int'(out_valid), 0);
    chk("post_reset_div_cal", int'(div_cal), 0);
    chk("post_reset_in_ready", int'(in_ready), 1);
    c0 = cal_cnt;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    chk("no_stale_result", nvalid, 0);
    chk("no_stale_cal", cal_cnt - c0, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
endmodule
